// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared FSM states, stage indices and mask helper for the hazard controller
package pipe_hazard_ctrl_pkg;
   typedef enum logic [1:0] {RUN, DRAIN, HOLDOFF} state_e;
   localparam int STG_PC      = 0;
   localparam int STG_IF_ID   = 1;
   localparam int STG_ID_EXE  = 2;
   localparam int STG_EXE_MEM = 3;
   localparam int STG_MEM_WB  = 4;
   localparam logic STOP = 1'b1;
   localparam logic ZERO = 1'b0;
   function automatic logic [31:0] low_mask(input int unsigned n);
      return (n >= 32) ? '1 : (32'd1 << n) - 32'd1;
   endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-side request/redirect bundle between the stages and the hazard controller
interface pipe_hazard_ctrl_if #(
   parameter int ADDR_WIDTH    = 32,
   parameter int NUM_STAGES    = 6,
   parameter int NUM_STALL_SRC = 2
);
   logic [NUM_STALL_SRC-1:0] stall_req_i;
   logic                     jump_en_i;
   logic [ADDR_WIDTH-1:0]    jump_addr_i;
   logic [ADDR_WIDTH-1:0]    pc_i;
   logic                     pc_vld_i;
   logic                     int_req_i;
   logic [ADDR_WIDTH-1:0]    isr_pc_i;
   logic [NUM_STAGES-1:0]    stall_o;
   logic [NUM_STAGES-1:0]    flush_o;
   logic                     new_pc_vld_o;
   logic [ADDR_WIDTH-1:0]    new_pc_o;
   logic                     int_ack_o;
   logic [ADDR_WIDTH-1:0]    epc_o;
   logic                     stall_timeout_o;
   modport master (
      output stall_req_i, jump_en_i, jump_addr_i, pc_i, pc_vld_i, int_req_i, isr_pc_i,
      input  stall_o, flush_o, new_pc_vld_o, new_pc_o, int_ack_o, epc_o, stall_timeout_o
   );
   modport slave (
      input  stall_req_i, jump_en_i, jump_addr_i, pc_i, pc_vld_i, int_req_i, isr_pc_i,
      output stall_o, flush_o, new_pc_vld_o, new_pc_o, int_ack_o, epc_o, stall_timeout_o
   );
endinterface

// File: rtl/pipe_hazard_ctrl_stall_watchdog.sv
// pipe_hazard_ctrl_stall_watchdog: counts a continuous stall episode and pulses once when it runs too long
module pipe_hazard_ctrl_stall_watchdog #(
   parameter int STALL_TIMEOUT = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic stall_i,
   output logic timeout_o
);
   localparam int W = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT + 1) : 1;
   localparam logic [W-1:0] LAST = W'((STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0);
   localparam logic [W-1:0] SAT  = W'(STALL_TIMEOUT);
   localparam logic EN = STALL_TIMEOUT > 0;
   logic [W-1:0] cnt_q, cnt_d;
   // Count stalled cycles, saturating so the episode yields a single pulse
   always_comb begin
      cnt_d     = !stall_i ? '0 : (cnt_q == SAT) ? cnt_q : cnt_q + 1'b1;
      timeout_o = EN && stall_i && (cnt_q == LAST);
   end
   // Counter register
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: merges stall sources, issues jump flushes/redirects and sequences interrupt entry
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH    = 32,
   parameter int NUM_STAGES    = 6,
   parameter int NUM_STALL_SRC = 2,
   parameter logic [4*NUM_STALL_SRC-1:0] STALL_DEPTH = {4'd4, 4'd3},
   parameter logic [NUM_STALL_SRC-1:0]   BLOCK_MASK  = 2'b10,
   parameter int JUMP_FLUSH    = 2,
   parameter int INT_HOLDOFF   = 3,
   parameter int STALL_TIMEOUT = 1024
) (
   input logic clk_i,
   input logic rst_ni,
   pipe_hazard_ctrl_if.slave bus
);
   localparam int HW = (INT_HOLDOFF > 1) ? $clog2(INT_HOLDOFF) : 1;
   localparam logic [HW-1:0] HOLD_INIT = HW'(INT_HOLDOFF - 1);
   localparam logic [NUM_STAGES-1:0] JMASK =
      NUM_STAGES'(low_mask(JUMP_FLUSH + 1) & ~(32'd1 << STG_PC));
   state_e                state_q, state_d;
   logic [HW-1:0]         hold_q, hold_d;
   logic [ADDR_WIDTH-1:0] last_pc_q, last_pc_d, epc_q, epc_d, resume_pc;
   logic [NUM_STAGES-1:0] stall_raw;
   logic                  blocked, take, jump;
   // Stall merge, take decision, redirect muxing and next-state logic; all outputs gated in reset
   always_comb begin
      stall_raw = '0;
      for (int i = 0; i < NUM_STALL_SRC; i++)
         if (bus.stall_req_i[i])
            stall_raw |= NUM_STAGES'(low_mask(int'(STALL_DEPTH[4*i +: 4])));
      blocked          = |(bus.stall_req_i & BLOCK_MASK);
      take             = rst_ni && bus.int_req_i && !blocked && (state_q != HOLDOFF);
      jump             = rst_ni && bus.jump_en_i;
      resume_pc        = bus.pc_vld_i ? bus.pc_i : bus.jump_en_i ? bus.jump_addr_i : last_pc_q;
      bus.stall_o      = (rst_ni && !take) ? stall_raw : '0;
      bus.flush_o      = take ? {NUM_STAGES{STOP}} : jump ? JMASK : {NUM_STAGES{ZERO}};
      bus.new_pc_vld_o = take || jump;
      bus.new_pc_o     = take ? bus.isr_pc_i : jump ? bus.jump_addr_i : '0;
      bus.int_ack_o    = take;
      bus.epc_o        = epc_q;
      state_d          = (state_q == HOLDOFF) ? ((hold_q == '0) ? RUN : HOLDOFF)
                       : take ? HOLDOFF : (bus.int_req_i && blocked) ? DRAIN : RUN;
      hold_d           = take ? HOLD_INIT
                       : (state_q == HOLDOFF && hold_q != '0) ? hold_q - 1'b1 : hold_q;
      last_pc_d        = bus.pc_vld_i ? bus.pc_i : bus.jump_en_i ? bus.jump_addr_i : last_pc_q;
      epc_d            = take ? resume_pc : epc_q;
   end
   // State, holdoff counter, last seen PC and EPC registers
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q   <= RUN;
         hold_q    <= '0;
         last_pc_q <= '0;
         epc_q     <= '0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         last_pc_q <= last_pc_d;
         epc_q     <= epc_d;
      end
   pipe_hazard_ctrl_stall_watchdog #(.STALL_TIMEOUT(STALL_TIMEOUT)) u_wdog (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .stall_i  (|bus.stall_o),
      .timeout_o(bus.stall_timeout_o)
   );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with hand-computed expectations for the hazard controller
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   pulses, pulse_cyc;
   pipe_hazard_ctrl_if #(.ADDR_WIDTH(32), .NUM_STAGES(6), .NUM_STALL_SRC(2)) bus ();
   pipe_hazard_ctrl #(.STALL_TIMEOUT(8)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      bus.stall_req_i = 2'b11;
      bus.jump_en_i   = 1'b1;
      bus.jump_addr_i = 32'h44;
      bus.pc_i        = '0;
      bus.pc_vld_i    = 1'b0;
      bus.int_req_i   = 1'b0;
      bus.isr_pc_i    = 32'h1000;
      #1;
      check("rst_stall", bus.stall_o, 6'h0);
      check("rst_flush", bus.flush_o, 6'h0);
      check("rst_vld", bus.new_pc_vld_o, 1'b0);
      check("rst_newpc", bus.new_pc_o, 32'h0);
      check("rst_epc", bus.epc_o, 32'h0);
      tick();
      tick();
      bus.stall_req_i = 2'b00;
      bus.jump_en_i   = 1'b0;
      rst_n           = 1'b1;
      #1;
      check("idle_vld", bus.new_pc_vld_o, 1'b0);
      bus.stall_req_i = 2'b01; #1; check("stall_01", bus.stall_o, 6'b000111);
      bus.stall_req_i = 2'b10; #1; check("stall_10", bus.stall_o, 6'b001111);
      bus.stall_req_i = 2'b11; #1; check("stall_11", bus.stall_o, 6'b001111);
      bus.stall_req_i = 2'b00;
      bus.jump_en_i   = 1'b1;
      bus.jump_addr_i = 32'h80;
      #1;
      check("jmp_flush", bus.flush_o, 6'b000110);
      check("jmp_newpc", bus.new_pc_o, 32'h80);
      check("jmp_vld", bus.new_pc_vld_o, 1'b1);
      tick();
      bus.jump_en_i   = 1'b0;
      bus.int_req_i   = 1'b1;
      bus.stall_req_i = 2'b10;
      bus.pc_vld_i    = 1'b1;
      bus.pc_i        = 32'h104;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("drain_noack", bus.int_ack_o, 1'b0);
         tick();
      end
      bus.stall_req_i = 2'b00;
      #1;
      check("take_ack", bus.int_ack_o, 1'b1);
      check("take_flush", bus.flush_o, 6'b111111);
      check("take_newpc", bus.new_pc_o, 32'h1000);
      tick();
      check("epc_pc", bus.epc_o, 32'h104);
      for (int i = 0; i < 3; i++) begin
         check("holdoff_noack", bus.int_ack_o, 1'b0);
         tick();
      end
      check("reack", bus.int_ack_o, 1'b1);
      bus.int_req_i = 1'b0;
      bus.pc_vld_i  = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      bus.jump_en_i   = 1'b1;
      bus.jump_addr_i = 32'h200;
      bus.int_req_i   = 1'b1;
      #1;
      check("jt_ack", bus.int_ack_o, 1'b1);
      check("jt_newpc", bus.new_pc_o, 32'h1000);
      check("jt_flush", bus.flush_o, 6'b111111);
      tick();
      check("jt_epc", bus.epc_o, 32'h200);
      bus.jump_en_i = 1'b0;
      bus.int_req_i = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      pulses          = 0;
      pulse_cyc       = 0;
      bus.stall_req_i = 2'b01;
      for (int c = 1; c <= 20; c++) begin
         #1;
         if (bus.stall_timeout_o) begin
            pulses++;
            pulse_cyc = c;
         end
         tick();
      end
      check("wd_pulses", 64'(pulses), 64'd1);
      check("wd_cycle", 64'(pulse_cyc), 64'd8);
      bus.stall_req_i = 2'b10;
      bus.int_req_i   = 1'b1;
      #1;
      check("pre_drain_noack", bus.int_ack_o, 1'b0);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_stall", bus.stall_o, 6'h0);
      check("mid_rst_ack", bus.int_ack_o, 1'b0);
      check("mid_rst_epc", bus.epc_o, 32'h0);
      check("mid_rst_vld", bus.new_pc_vld_o, 1'b0);
      tick();
      rst_n           = 1'b1;
      bus.stall_req_i = 2'b00;
      #1;
      check("post_rst_ack", bus.int_ack_o, 1'b1);
      tick();
      bus.int_req_i = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
